// File: rtl/mult_stream_ctrl.sv
// Valid/ready front end for a fixed-latency pipelined multiplier: issues operands,
// tags them through the pipeline, and collects products in a FWFT result FIFO.
module mult_stream_ctrl #(
  parameter int WIDTH    = 16,
  parameter int MULT_LAT = 5,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic [2*WIDTH-1:0]       mult_p,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out_p,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a beat transfers on a rising edge where valid && ready; valid never
  // waits on ready, and in_ready depends on registered state only.
  logic [CW-1:0]       credits;
  logic [MULT_LAT-1:0] vld_sr;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [2*WIDTH-1:0]  mem [DEPTH];

  logic fire;
  logic pop;
  logic push;

  assign mult_a    = in_a;
  assign mult_b    = in_b;
  assign in_ready  = rst_n && (credits < CW'(DEPTH));
  assign out_valid = (out_count != '0);
  assign busy      = (credits != '0);
  assign fire      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push      = vld_sr[MULT_LAT-1];
  assign out_p     = out_valid ? mem[rd_ptr] : '0;

  // A credit is held from issue until its product leaves the FIFO, so the FIFO
  // always has room for everything still inside the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= '0;
    end else begin
      case ({fire, pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // The multiplier has no valid of its own; this tag rides alongside its pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | MULT_LAT'(fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   out_count <= out_count + CW'(1);
        2'b01:   out_count <= out_count - CW'(1);
        default: out_count <= out_count;
      endcase
    end
  end

  // Storage is intentionally not reset; out_p masks it while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mult_p;
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (out_count == CW'(DEPTH))))
    else $error("push into full result FIFO");

endmodule

// File: tb/tb_mult_stream_ctrl.sv
// Directed bench for mult_stream_ctrl with a behavioural 5-stage multiplier and
// a product scoreboard fed from the operand handshake.
module tb_mult_stream_ctrl;

  localparam int WIDTH    = 16;
  localparam int MULT_LAT = 5;
  localparam int DEPTH    = 8;
  localparam int PW       = 2 * WIDTH;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic [WIDTH-1:0]       mult_a;
  logic [WIDTH-1:0]       mult_b;
  logic [PW-1:0]          mult_p;
  logic                   out_valid;
  logic                   out_ready;
  logic [PW-1:0]          out_p;
  logic [$clog2(DEPTH):0] out_count;
  logic                   busy;

  int n_total  = 0;
  int n_passed = 0;
  int fire_cnt = 0;
  int pop_cnt  = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mpipe [MULT_LAT];

  mult_stream_ctrl #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_count (out_count),
    .busy      (busy)
  );

  // clock / multiplier model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mpipe[0] <= PW'(mult_a) * PW'(mult_b);
    for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mult_p = mpipe[MULT_LAT-1];

  // scoreboard: sampled on the falling edge, where all handshake signals are settled
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(PW'(in_a) * PW'(in_b));
        fire_cnt++;
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: out_p=%h popped with no result expected", out_p);
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          if (out_p !== e) $display("FAIL sb_data: out_p=%h expected %h", out_p, e);
          else n_passed++;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < max_cycles && (exp_q.size() != 0 || out_valid); i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    tick(); tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_passed++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_passed++;
    n_total++; if (out_p !== '0) $display("FAIL rst_out_p: got %h want 0", out_p); else n_passed++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_passed++;
    n_total++; if (out_count !== '0) $display("FAIL rst_out_count: got %0d want 0", out_count); else n_passed++;
    rst_n = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else n_passed++;
  endtask

  task automatic test_single();
    int ticks;
    in_a = 16'd3; in_b = 16'd7; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    ticks = 0;
    while (!out_valid && ticks < 20) begin tick(); ticks++; end
    // out_valid is seen by the consumer at the edge following this sample
    n_total++;
    if (ticks + 1 !== MULT_LAT + 1) $display("FAIL single_latency: got %0d edges want %0d", ticks + 1, MULT_LAT + 1);
    else n_passed++;
    n_total++; if (out_p !== 32'd21) $display("FAIL single_data: got %h want 00000015", out_p); else n_passed++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else n_passed++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_empty: got %b want 0", out_valid); else n_passed++;
  endtask

  task automatic test_stream();
    int p0, ready_drops;
    p0 = pop_cnt; ready_drops = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_a = 16'($urandom_range(0, 16'hFFFF));
      in_b = 16'($urandom_range(0, 16'hFFFF));
      if (in_ready !== 1'b1) ready_drops++;
      tick();
    end
    drain(50);
    n_total++; if (ready_drops != 0) $display("FAIL stream_ready: got %0d drops want 0", ready_drops); else n_passed++;
    n_total++; if (pop_cnt - p0 != 32) $display("FAIL stream_count: got %0d results want 32", pop_cnt - p0); else n_passed++;
  endtask

  task automatic test_backpressure();
    int f, p0, w;
    f = 0; p0 = pop_cnt;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_a = 16'(i + 1); in_b = 16'(i + 2);
      if (in_ready) f++;
      tick();
    end
    n_total++; if (f != DEPTH) $display("FAIL bp_fires: got %0d want %0d", f, DEPTH); else n_passed++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", in_ready); else n_passed++;
    w = 0;
    while (out_count != 4'(DEPTH) && w < 10) begin tick(); w++; end
    n_total++; if (out_count !== 4'(DEPTH)) $display("FAIL bp_count: got %0d want %0d", out_count, DEPTH); else n_passed++;
    in_a = 16'd100; in_b = 16'd200; out_ready = 1'b1;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_resume: got %b want 1", in_ready); else n_passed++;
    tick();
    in_valid = 1'b0;
    w = 0;
    while (pop_cnt - p0 < DEPTH + 1 && w < 40) begin tick(); w++; end
    n_total++; if (pop_cnt - p0 != DEPTH + 1) $display("FAIL bp_results: got %0d want %0d", pop_cnt - p0, DEPTH + 1); else n_passed++;
    drain(20);
  endtask

  task automatic test_corners();
    logic [WIDTH-1:0] va [3];
    logic [WIDTH-1:0] vb [3];
    logic [PW-1:0]    vp [3];
    int w;
    va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vp[0] = 32'hFFFE0001;
    va[1] = 16'h0000; vb[1] = 16'hFFFF; vp[1] = 32'h00000000;
    va[2] = 16'h8000; vb[2] = 16'h0002; vp[2] = 32'h00010000;
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0; in_a = va[i]; in_b = vb[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 20) begin tick(); w++; end
      n_total++;
      if (out_valid !== 1'b1 || out_p !== vp[i]) $display("FAIL corner_%0d: valid=%b out_p=%h want %h", i, out_valid, out_p, vp[i]);
      else n_passed++;
      out_ready = 1'b1;
      tick();
    end
    // fill all credits, then pop alone, then pop+fire together, then one more fire
    out_ready = 1'b0; in_valid = 1'b1; in_a = 16'd11; in_b = 16'd13;
    w = 0;
    while (in_ready && w < 20) begin tick(); w++; end
    in_valid = 1'b0;
    w = 0;
    while (out_count != 4'(DEPTH) && w < 10) begin tick(); w++; end
    n_total++; if (out_count !== 4'(DEPTH)) $display("FAIL same_fill: got %0d want %0d", out_count, DEPTH); else n_passed++;
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL same_pop_ready: got %b want 1", in_ready); else n_passed++;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL same_firepop_ready: got %b want 1", in_ready); else n_passed++;
    out_ready = 1'b0;
    tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL same_credits7: got %b want 0", in_ready); else n_passed++;
    drain(40);
  endtask

  task automatic test_reset_midflight();
    int spurious, w;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = 16'(i + 20); in_b = 16'(i + 30);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready: got %b want 0", in_ready); else n_passed++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_passed++;
    n_total++; if (out_p !== '0) $display("FAIL mid_out_p: got %h want 0", out_p); else n_passed++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_passed++;
    n_total++; if (out_count !== '0) $display("FAIL mid_out_count: got %0d want 0", out_count); else n_passed++;
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) spurious++;
    end
    n_total++; if (spurious != 0) $display("FAIL mid_spurious: got %0d valid cycles want 0", spurious); else n_passed++;
    out_ready = 1'b0; in_a = 16'd5; in_b = 16'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin tick(); w++; end
    n_total++;
    if (out_valid !== 1'b1 || out_p !== 32'd25) $display("FAIL mid_after: valid=%b out_p=%h want 00000019", out_valid, out_p);
    else n_passed++;
    drain(20);
  endtask

  task automatic test_random();
    int f0, p0, cyc;
    f0 = fire_cnt; p0 = pop_cnt; cyc = 0;
    while (fire_cnt - f0 < 1000 && cyc < 20000) begin
      in_a      = 16'($urandom_range(0, 16'hFFFF));
      in_b      = 16'($urandom_range(0, 16'hFFFF));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
      // stop issuing once the last op has been accepted
      if (fire_cnt - f0 >= 1000) in_valid = 1'b0;
    end
    drain(100);
    n_total++; if (fire_cnt - f0 != 1000) $display("FAIL rand_fires: got %0d want 1000", fire_cnt - f0); else n_passed++;
    n_total++; if (pop_cnt - p0 != 1000) $display("FAIL rand_pops: got %0d want 1000", pop_cnt - p0); else n_passed++;
    n_total++; if (exp_q.size() != 0) $display("FAIL rand_leftover: got %0d want 0", exp_q.size()); else n_passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_corners();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
